// File: rtl/gmt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// gmt_tx_scheduler
// Timed transmit controller for the GMT serial encoder (40 MHz domain).
// A small queue holds 32-bit GMT messages, each tagged with a WR cycle
// timestamp or an "immediate" flag. The block generates the encoder BitRate
// tick and issues a start pulse when the head message becomes due. Messages
// found too far past their timestamp are dropped and counted.
//
// Ports
//   clk_40m_i      40 MHz clock (encoder clock)
//   rst_n_i        asynchronous active-low reset
//   enable_i       1 = messages may be started; 0 = hold head (tick keeps running)
//   flush_i        1-cycle: empty queue, clear sticky flags, return to IDLE
//   push_*         enqueue strobe, immediate flag, target timestamp, message
//   full_o         queue full
//   tm_valid_i     WR time valid
//   tm_cycles_i    WR cycle counter, wraps at g_cycles_max
//   enc_bitrate_o  one-cycle BitRate tick to the encoder
//   enc_data_o     message to encoder, stable from start until done
//   enc_start_o    one-cycle start pulse
//   enc_done_i     encoder done level; rising edge = message complete
//   busy_o         FSM not idle or queue non-empty
//   overflow_o     sticky: push while full
//   timeout_o      sticky: encoder done not seen in time
//   sent_cnt_o     saturating count of started messages
//   late_cnt_o     saturating count of dropped late messages
// -----------------------------------------------------------------------------
module gmt_tx_scheduler #(
  parameter int g_fifo_log2    = 4,
  parameter int g_bitrate_div  = 40,
  parameter int g_cycles_max   = 125000000,
  parameter int g_late_window  = 1250,
  parameter int g_gap_ticks    = 2,
  parameter int g_done_timeout = 4095
) (
  input  logic        clk_40m_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        push_imm_i,
  input  logic [27:0] push_tstamp_i,
  input  logic [31:0] push_data_i,
  output logic        full_o,
  input  logic        tm_valid_i,
  input  logic [27:0] tm_cycles_i,
  output logic        enc_bitrate_o,
  output logic [31:0] enc_data_o,
  output logic        enc_start_o,
  input  logic        enc_done_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic [15:0] sent_cnt_o,
  output logic [15:0] late_cnt_o
);

  localparam int DEPTH = 1 << g_fifo_log2;
  localparam int TW    = $clog2(g_bitrate_div);
  localparam int TOW   = $clog2(g_done_timeout + 1);
  localparam int GW    = $clog2(g_gap_ticks + 1);

  localparam logic [31:0] CYC_MAX  = 32'(g_cycles_max);
  localparam logic [31:0] LATE_WIN = 32'(g_late_window);
  localparam logic [31:0] HALF_MAX = 32'(g_cycles_max / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DUE, S_START, S_WAIT_DONE, S_GAP
  } state_t;

  typedef struct packed {
    logic        imm;
    logic [27:0] tstamp;
    logic [31:0] data;
  } entry_t;

  state_t                 state;
  entry_t                 mem [DEPTH];
  entry_t                 head;
  logic [g_fifo_log2-1:0] wr_ptr, rd_ptr;
  logic [g_fifo_log2:0]   count;
  logic                   empty, push_ok, pop;
  logic [TW-1:0]          tick_cnt;
  logic [TOW-1:0]         to_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   done_q;
  logic [31:0]            lag;
  logic                   is_due, is_late, go_start, go_drop;

  // ---------------------------------------------------------------------------
  // BitRate tick: free-running divider, tick registered one cycle after cnt==0
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_40m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt      <= '0;
      enc_bitrate_o <= 1'b0;
    end else begin
      enc_bitrate_o <= (tick_cnt == '0);
      tick_cnt      <= (tick_cnt == TW'(g_bitrate_div - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue. count can reach exactly DEPTH, so its MSB alone means full.
  // ---------------------------------------------------------------------------
  assign empty   = (count == '0);
  assign full_o  = count[g_fifo_log2];
  assign head    = mem[rd_ptr];
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop     = !flush_i && !empty &&
                   ((state == S_START) || (state == S_WAIT_DUE && enable_i && go_drop));

  // NOTE: the storage array has no reset; only pointers and count need one,
  // and entries are never read before being written.
  always_ff @(posedge clk_40m_i) begin
    if (push_ok) mem[wr_ptr] <= '{imm: push_imm_i, tstamp: push_tstamp_i, data: push_data_i};
  end

  always_ff @(posedge clk_40m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_i && full_o) overflow_o <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lag of current WR time behind head timestamp, modulo the cycle wrap.
  // A large lag (>= half a second) means the timestamp is still in the future.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lag = 32'd0;
    if ({4'd0, tm_cycles_i} >= {4'd0, head.tstamp})
      lag = {4'd0, tm_cycles_i} - {4'd0, head.tstamp};
    else
      lag = {4'd0, tm_cycles_i} + CYC_MAX - {4'd0, head.tstamp};
  end

  assign is_due   = (lag < LATE_WIN);
  assign is_late  = !is_due && (lag < HALF_MAX);
  assign go_start = head.imm || (tm_valid_i && is_due);
  assign go_drop  = !head.imm && tm_valid_i && is_late;

  assign busy_o = (state != S_IDLE) || !empty;

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_40m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      enc_start_o <= 1'b0;
      enc_data_o  <= '0;
      sent_cnt_o  <= '0;
      late_cnt_o  <= '0;
      timeout_o   <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= enc_done_i;
      enc_start_o <= 1'b0;
      if (flush_i) begin
        state     <= S_IDLE;
        timeout_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (!empty && enable_i) state <= S_WAIT_DUE;
          S_WAIT_DUE:
            if (!enable_i) begin
              state <= S_IDLE;
            end else if (go_start) begin
              state       <= S_START;
              enc_start_o <= 1'b1;
              enc_data_o  <= head.data;
            end else if (go_drop) begin
              state <= S_IDLE;
              if (late_cnt_o != 16'hFFFF) late_cnt_o <= late_cnt_o + 16'd1;
            end
          S_START: begin
            state  <= S_WAIT_DONE;
            to_cnt <= '0;
            if (sent_cnt_o != 16'hFFFF) sent_cnt_o <= sent_cnt_o + 16'd1;
          end
          S_WAIT_DONE:
            if (enc_done_i && !done_q) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end else if (to_cnt == TOW'(g_done_timeout - 1)) begin
              state     <= S_GAP;
              gap_cnt   <= '0;
              timeout_o <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          S_GAP:
            if (enc_bitrate_o) begin
              if (gap_cnt == GW'(g_gap_ticks - 1)) state <= S_IDLE;
              else                                 gap_cnt <= gap_cnt + 1'b1;
            end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gmt_tx_scheduler
// Directed bench for gmt_tx_scheduler: reset values, BitRate period,
// immediate and timed sends, late drops at the window boundary, timestamp
// wrap, queue full/overflow/flush, encoder timeout and async reset in flight.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gmt_tx_scheduler;

  logic        clk_40m_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i, flush_i, push_i, push_imm_i;
  logic [27:0] push_tstamp_i;
  logic [31:0] push_data_i;
  logic        full_o;
  logic        tm_valid_i;
  logic [27:0] tm_cycles_i;
  logic        enc_bitrate_o;
  logic [31:0] enc_data_o;
  logic        enc_start_o;
  logic        enc_done_i;
  logic        busy_o, overflow_o, timeout_o;
  logic [15:0] sent_cnt_o, late_cnt_o;

  int checks = 0;
  int errors = 0;

  always #12.5 clk_40m_i = ~clk_40m_i;

  gmt_tx_scheduler dut (
    .clk_40m_i    (clk_40m_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .push_imm_i   (push_imm_i),
    .push_tstamp_i(push_tstamp_i),
    .push_data_i  (push_data_i),
    .full_o       (full_o),
    .tm_valid_i   (tm_valid_i),
    .tm_cycles_i  (tm_cycles_i),
    .enc_bitrate_o(enc_bitrate_o),
    .enc_data_o   (enc_data_o),
    .enc_start_o  (enc_start_o),
    .enc_done_i   (enc_done_i),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .timeout_o    (timeout_o),
    .sent_cnt_o   (sent_cnt_o),
    .late_cnt_o   (late_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_40m_i);
      #1;
    end
  endtask

  task automatic push(input logic imm, input logic [27:0] ts, input logic [31:0] d);
    push_i = 1'b1; push_imm_i = imm; push_tstamp_i = ts; push_data_i = d;
    step();
    push_i = 1'b0;
  endtask

  // Steps until enc_start_o is seen; cyc = steps taken, or -1 if not within max.
  task automatic wait_start(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (enc_start_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_starts(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (enc_start_o) cnt++;
    end
  endtask

  task automatic done_pulse();
    enc_done_i = 1'b1;
    step();
    enc_done_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},   enc_start_o,   1'b0);
    check({tag, "_bitrate"}, enc_bitrate_o, 1'b0);
    check({tag, "_data"},    enc_data_o,    32'h0);
    check({tag, "_busy"},    busy_o,        1'b0);
    check({tag, "_full"},    full_o,        1'b0);
    check({tag, "_ovf"},     overflow_o,    1'b0);
    check({tag, "_tmo"},     timeout_o,     1'b0);
    check({tag, "_sent"},    sent_cnt_o,    16'h0);
    check({tag, "_late"},    late_cnt_o,    16'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, n, p;
    logic seen;

    rst_n_i = 1'b0; enable_i = 1'b0; flush_i = 1'b0; push_i = 1'b0;
    push_imm_i = 1'b0; push_tstamp_i = '0; push_data_i = '0;
    tm_valid_i = 1'b0; tm_cycles_i = '0; enc_done_i = 1'b0;
    step(3);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    step(2);

    // BitRate tick: one cycle wide, period 40
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (enc_bitrate_o) begin seen = 1'b1; break; end
      step();
    end
    check("tick_seen", seen, 1'b1);
    step();
    check("tick_width", enc_bitrate_o, 1'b0);
    p = 1;
    while (!enc_bitrate_o && p < 100) begin step(); p++; end
    check("tick_period", 32'(p), 32'd40);

    // Immediate send
    enable_i = 1'b1;
    push(1'b1, 28'd0, 32'hDEADBEEF);
    wait_start(10, c);
    check("imm_start", (c >= 1), 1'b1);
    check("imm_data", enc_data_o, 32'hDEADBEEF);
    step();
    check("imm_pulse_width", enc_start_o, 1'b0);
    check("imm_sent", sent_cnt_o, 16'd1);
    push(1'b1, 28'd0, 32'h12345678);
    count_starts(20, n);
    check("no_start_before_done", 32'(n), 32'd0);
    check("data_stable", enc_data_o, 32'hDEADBEEF);
    done_pulse();
    wait_start(120, c);
    check("gap_after_done", (c >= 41 && c <= 90), 1'b1);
    check("imm2_data", enc_data_o, 32'h12345678);
    step();
    check("imm2_sent", sent_cnt_o, 16'd2);
    done_pulse();
    wait_idle("idle_after_imm", 200);

    // Timed send at tm+4000
    tm_valid_i = 1'b1;
    tm_cycles_i = 28'd1000;
    push(1'b0, 28'd5000, 32'hA5A50001);
    count_starts(20, n);
    check("no_early_far", 32'(n), 32'd0);
    tm_cycles_i = 28'd4999;
    count_starts(5, n);
    check("no_early_edge", 32'(n), 32'd0);
    tm_cycles_i = 28'd5000;
    wait_start(2, c);
    check("due_latency", (c >= 1 && c <= 2), 1'b1);
    check("due_data", enc_data_o, 32'hA5A50001);
    step();
    check("due_late_cnt", late_cnt_o, 16'd0);
    check("due_sent", sent_cnt_o, 16'd3);
    done_pulse();
    wait_idle("idle_after_due", 200);

    // Late drop: tstamp = tm - 5000
    tm_cycles_i = 28'd20000;
    push(1'b0, 28'd15000, 32'hBAD00001);
    count_starts(10, n);
    check("late_no_start", 32'(n), 32'd0);
    check("late_cnt_1", late_cnt_o, 16'd1);
    check("late_queue_empty", busy_o, 1'b0);
    check("late_sent_kept", sent_cnt_o, 16'd3);

    // Window boundary: lag 1250 is late, lag 1249 is sent
    tm_cycles_i = 28'd30000;
    push(1'b0, 28'd28750, 32'hBAD01250);
    count_starts(10, n);
    check("lag1250_no_start", 32'(n), 32'd0);
    check("lag1250_late_cnt", late_cnt_o, 16'd2);
    push(1'b0, 28'd28751, 32'hB0B01249);
    wait_start(10, c);
    check("lag1249_start", (c >= 1), 1'b1);
    check("lag1249_data", enc_data_o, 32'hB0B01249);
    step();
    check("lag1249_late_cnt", late_cnt_o, 16'd2);
    check("lag1249_sent", sent_cnt_o, 16'd4);
    done_pulse();
    wait_idle("idle_after_boundary", 200);

    // Timestamp just before the wrap, released after tm wraps to 2
    tm_cycles_i = 28'd124999980;
    push(1'b0, 28'd124999990, 32'hC0DE0001);
    count_starts(10, n);
    check("wrap_wait_far", 32'(n), 32'd0);
    tm_cycles_i = 28'd124999989;
    count_starts(5, n);
    check("wrap_wait_edge", 32'(n), 32'd0);
    tm_cycles_i = 28'd2;
    wait_start(2, c);
    check("wrap_start", (c >= 1 && c <= 2), 1'b1);
    check("wrap_data", enc_data_o, 32'hC0DE0001);
    step();
    check("wrap_sent", sent_cnt_o, 16'd5);
    check("wrap_late_cnt", late_cnt_o, 16'd2);
    done_pulse();
    wait_idle("idle_after_wrap", 200);

    // Fill queue with enable low, overflow, then flush
    enable_i = 1'b0;
    tm_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) push(1'b1, 28'd0, 32'(i));
    check("full_after_15", full_o, 1'b0);
    push(1'b1, 28'd0, 32'hF);
    check("full_after_16", full_o, 1'b1);
    check("no_ovf_at_16", overflow_o, 1'b0);
    push(1'b1, 28'd0, 32'h10);
    check("ovf_after_17", overflow_o, 1'b1);
    check("busy_when_full", busy_o, 1'b1);
    check("no_send_disabled", sent_cnt_o, 16'd5);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy", busy_o, 1'b0);
    check("flush_ovf", overflow_o, 1'b0);
    check("flush_full", full_o, 1'b0);
    enable_i = 1'b1;
    count_starts(10, n);
    check("flush_nothing_left", 32'(n), 32'd0);

    // Encoder done stuck low
    push(1'b1, 28'd0, 32'hFEEDF00D);
    wait_start(10, c);
    check("tmo_start", (c >= 1), 1'b1);
    step(4000);
    check("tmo_not_early", timeout_o, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (timeout_o) begin seen = 1'b1; break; end
    end
    check("tmo_set", seen, 1'b1);
    wait_idle("tmo_back_idle", 200);
    check("tmo_sent", sent_cnt_o, 16'd6);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("tmo_flush_clear", timeout_o, 1'b0);

    // Async reset while waiting for done
    push(1'b1, 28'd0, 32'h5555AAAA);
    wait_start(10, c);
    check("rst_start", (c >= 1), 1'b1);
    step(3);
    check("rst_busy_before", busy_o, 1'b1);
    #5 rst_n_i = 1'b0;
    #1;
    check_all_zero("async_rst");
    step(2);
    rst_n_i = 1'b1;
    count_starts(5, n);
    check("post_rst_no_start", 32'(n), 32'd0);
    check("post_rst_sent", sent_cnt_o, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
